// File: rtl/router_pkg.sv
// +-----------------------------------------------------------------------+
// | router_pkg : shared state encoding and default sizing for the router  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package router_pkg;

    localparam int c_DEF_SPAD_DATA_WIDTH = 64;
    localparam int c_DEF_DATA_WIDTH      = 8;
    localparam int c_DEF_ADDR_WIDTH      = 8;
    localparam int c_DEF_N_CH            = 4;
    localparam int c_DEF_BUF_WORDS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_READY  = 3'd3,
        ST_STREAM = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spad.sv
// +-----------------------------------------------------------------------+
// | spad : single write / single read scratchpad, 1-cycle read latency    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module spad #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read-before-write: a same-cycle read of the written address sees old data.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mc_weight_router.sv
// +-----------------------------------------------------------------------+
// | mc_weight_router : loads weights from scratchpad into a local buffer  |
// | and streams them to N_CH parallel channel lanes. Rev 1.0              |
// +-----------------------------------------------------------------------+
`default_nettype none

module mc_weight_router
    import router_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = c_DEF_SPAD_DATA_WIDTH,
    parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = c_DEF_ADDR_WIDTH,
    parameter int N_CH            = c_DEF_N_CH,
    parameter int BUF_WORDS       = c_DEF_BUF_WORDS
) (
    input  logic                             i_clk,
    input  logic                             i_nrst,
    input  logic                             i_reg_clear,
    input  logic                             i_start,
    input  logic                             i_spad_write_en,
    input  logic [ADDR_WIDTH-1:0]            i_write_addr,
    input  logic [SPAD_DATA_WIDTH-1:0]       i_data_in,
    input  logic [ADDR_WIDTH-1:0]            i_start_addr,
    input  logic [$clog2(BUF_WORDS+1)-1:0]   i_num_words,
    input  logic [ADDR_WIDTH-1:0]            i_route_size,
    input  logic [$clog2(N_CH+1)-1:0]        i_ch_active,
    input  logic [7:0]                       i_reuse_cnt,
    input  logic                             i_pop_en,
    output logic                             o_ready,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [N_CH*DATA_WIDTH-1:0]       o_data,
    output logic [N_CH-1:0]                  o_data_valid
);

    localparam int SPAD_N = SPAD_DATA_WIDTH / DATA_WIDTH;
    localparam int BUF_N  = BUF_WORDS * SPAD_N;
    localparam int NW_W   = $clog2(BUF_WORDS + 1);
    localparam int CH_W   = $clog2(N_CH + 1);
    localparam int BW_W   = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [ADDR_WIDTH-1:0]          r_start_addr;
    logic [NW_W-1:0]                r_num_words;
    logic [ADDR_WIDTH-1:0]          r_route_size;
    logic [CH_W-1:0]                r_ch_active;
    logic [7:0]                     r_reuse_cnt;
    logic [NW_W-1:0]                r_rd_cnt;
    logic                           r_rd_vld;
    logic [BW_W-1:0]                r_rd_widx;
    logic [ADDR_WIDTH-1:0]          r_idx;
    logic [7:0]                     r_replay;
    logic [SPAD_DATA_WIDTH-1:0]     r_buf [BUF_WORDS];
    logic [N_CH*DATA_WIDTH-1:0]     r_data;
    logic [N_CH-1:0]                r_valid;

    logic [NW_W-1:0]                w_num_words_clamp;
    logic                           w_rd_en;
    logic [ADDR_WIDTH-1:0]          w_rd_addr;
    logic [SPAD_DATA_WIDTH-1:0]     w_spad_rdata;
    logic                           w_load_last;
    logic                           w_empty_route;
    logic                           w_idx_last;
    logic                           w_pop_last;
    logic                           w_can_pop;
    logic [BUF_N*DATA_WIDTH-1:0]    w_buf_flat;
    logic [N_CH*DATA_WIDTH-1:0]     w_lane_data;
    logic [N_CH-1:0]                w_lane_valid;

    assign w_num_words_clamp = (i_num_words > NW_W'(BUF_WORDS)) ? NW_W'(BUF_WORDS) : i_num_words;
    assign w_rd_en       = (r_state == ST_LOAD) && (r_num_words != '0) && !i_reg_clear;
    assign w_rd_addr     = r_start_addr + ADDR_WIDTH'(r_rd_cnt);
    assign w_load_last   = (r_rd_cnt == r_num_words - NW_W'(1));
    assign w_empty_route = (r_route_size == '0) || (r_ch_active == '0);
    assign w_idx_last    = (r_idx == r_route_size - ADDR_WIDTH'(1));
    assign w_pop_last    = w_idx_last && (r_replay >= r_reuse_cnt);
    assign w_can_pop     = ((r_state == ST_READY) || (r_state == ST_STREAM)) && i_pop_en;

    spad #(
        .DATA_WIDTH (SPAD_DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_spad (
        .i_clk   (i_clk),
        .i_we    (i_spad_write_en),
        .i_waddr (i_write_addr),
        .i_wdata (i_data_in),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_spad_rdata)
    );

    // Weight i of the buffer lives at bits [i*DATA_WIDTH +: DATA_WIDTH] of the flat view.
    for (genvar w = 0; w < BUF_WORDS; w++) begin : g_flat
        assign w_buf_flat[w*SPAD_DATA_WIDTH +: SPAD_DATA_WIDTH] = r_buf[w];
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        logic [31:0]                 w_widx;
        logic [BUF_N*DATA_WIDTH-1:0] w_shift;
        assign w_widx  = 32'(c) * 32'(r_route_size) + 32'(r_idx);
        assign w_shift = w_buf_flat >> (w_widx * 32'(DATA_WIDTH));
        assign w_lane_valid[c] = (32'(c) < 32'(r_ch_active));
        assign w_lane_data[c*DATA_WIDTH +: DATA_WIDTH] =
            (w_lane_valid[c] && (w_widx < 32'(BUF_N))) ? w_shift[DATA_WIDTH-1:0] : '0;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_reg_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    if (r_num_words == '0)  w_state_nxt = ST_READY;
                    else if (w_load_last)   w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    w_state_nxt = ST_READY;
                end
                ST_READY, ST_STREAM: begin
                    if (i_pop_en) begin
                        if (w_empty_route || w_pop_last) w_state_nxt = ST_DONE;
                        else                             w_state_nxt = ST_STREAM;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_start_addr <= '0;
            r_num_words  <= '0;
            r_route_size <= '0;
            r_ch_active  <= '0;
            r_reuse_cnt  <= '0;
            r_rd_cnt     <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_widx    <= '0;
            r_idx        <= '0;
            r_replay     <= '0;
            r_data       <= '0;
            r_valid      <= '0;
            for (int w = 0; w < BUF_WORDS; w++) r_buf[w] <= '0;
        end else if (i_reg_clear) begin
            r_rd_cnt  <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_widx <= '0;
            r_idx     <= '0;
            r_replay  <= '0;
            r_data    <= '0;
            r_valid   <= '0;
            for (int w = 0; w < BUF_WORDS; w++) r_buf[w] <= '0;
        end else begin
            r_rd_vld  <= w_rd_en;
            r_rd_widx <= r_rd_cnt[BW_W-1:0];
            r_data    <= '0;
            r_valid   <= '0;
            if (r_rd_vld) begin
                r_buf[r_rd_widx] <= w_spad_rdata;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_start_addr <= i_start_addr;
                        r_num_words  <= w_num_words_clamp;
                        r_route_size <= i_route_size;
                        r_ch_active  <= i_ch_active;
                        r_reuse_cnt  <= i_reuse_cnt;
                        r_rd_cnt     <= '0;
                        r_idx        <= '0;
                        r_replay     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_rd_en) r_rd_cnt <= r_rd_cnt + NW_W'(1);
                end
                default: ;
            endcase
            if (w_can_pop && !w_empty_route) begin
                r_data  <= w_lane_data;
                r_valid <= w_lane_valid;
                if (w_idx_last) begin
                    r_idx <= '0;
                    if (!w_pop_last) r_replay <= r_replay + 8'd1;
                end else begin
                    r_idx <= r_idx + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign o_ready      = (r_state == ST_READY) || (r_state == ST_STREAM);
    assign o_busy       = (r_state == ST_LOAD) || (r_state == ST_DRAIN) || (r_state == ST_STREAM);
    assign o_done       = (r_state == ST_DONE);
    assign o_data       = r_data;
    assign o_data_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mc_weight_router.sv
// +-----------------------------------------------------------------------+
// | tb_mc_weight_router : directed self-checking bench for the router     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mc_weight_router;

    localparam int SDW = 64;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int NCH = 4;
    localparam int BW  = 8;

    logic              i_clk = 1'b0;
    logic              i_nrst;
    logic              i_reg_clear;
    logic              i_start;
    logic              i_spad_write_en;
    logic [AW-1:0]     i_write_addr;
    logic [SDW-1:0]    i_data_in;
    logic [AW-1:0]     i_start_addr;
    logic [3:0]        i_num_words;
    logic [AW-1:0]     i_route_size;
    logic [2:0]        i_ch_active;
    logic [7:0]        i_reuse_cnt;
    logic              i_pop_en;
    logic              o_ready;
    logic              o_busy;
    logic              o_done;
    logic [NCH*DW-1:0] o_data;
    logic [NCH-1:0]    o_data_valid;

    int n_checks = 0;
    int n_errors = 0;

    mc_weight_router #(
        .SPAD_DATA_WIDTH (SDW),
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .N_CH            (NCH),
        .BUF_WORDS       (BW)
    ) u_dut (
        .i_clk           (i_clk),
        .i_nrst          (i_nrst),
        .i_reg_clear     (i_reg_clear),
        .i_start         (i_start),
        .i_spad_write_en (i_spad_write_en),
        .i_write_addr    (i_write_addr),
        .i_data_in       (i_data_in),
        .i_start_addr    (i_start_addr),
        .i_num_words     (i_num_words),
        .i_route_size    (i_route_size),
        .i_ch_active     (i_ch_active),
        .i_reuse_cnt     (i_reuse_cnt),
        .i_pop_en        (i_pop_en),
        .o_ready         (o_ready),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_data          (o_data),
        .o_data_valid    (o_data_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic spad_write(input logic [AW-1:0] addr, input logic [SDW-1:0] data);
        i_spad_write_en = 1'b1;
        i_write_addr    = addr;
        i_data_in       = data;
        tick();
        i_spad_write_en = 1'b0;
    endtask

    task automatic start_load(input logic [AW-1:0] sa, input logic [3:0] nw,
                              input logic [AW-1:0] rs, input logic [2:0] ca,
                              input logic [7:0] ru, output int n);
        i_pop_en     = 1'b0;
        i_start_addr = sa;
        i_num_words  = nw;
        i_route_size = rs;
        i_ch_active  = ca;
        i_reuse_cnt  = ru;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_data, input logic [3:0] exp_vld);
        i_pop_en = 1'b1;
        tick();
        check({tag, "_data"}, 64'(o_data), 64'(exp_data));
        check({tag, "_vld"}, 64'(o_data_valid), 64'(exp_vld));
    endtask

    logic [31:0] exp4 [4];
    int          n;
    logic [7:0]  l0, l1;

    initial begin
        exp4[0] = 32'h0D090501;
        exp4[1] = 32'h0E0A0602;
        exp4[2] = 32'h0F0B0703;
        exp4[3] = 32'h100C0804;

        i_nrst = 1'b0; i_reg_clear = 1'b0; i_start = 1'b0; i_spad_write_en = 1'b0;
        i_write_addr = '0; i_data_in = '0; i_start_addr = '0; i_num_words = '0;
        i_route_size = '0; i_ch_active = '0; i_reuse_cnt = '0; i_pop_en = 1'b0;
        tick();
        tick();
        check("rst_flags", 64'({o_ready, o_busy, o_done}), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_vld", 64'(o_data_valid), 64'd0);
        i_nrst = 1'b1;
        tick();

        spad_write(8'd0, 64'h0807060504030201);
        spad_write(8'd1, 64'h100F0E0D0C0B0A09);

        // Basic load and stream, reuse 0
        start_load(8'd0, 4'd2, 8'd4, 3'd4, 8'd0, n);
        check("load_lat", 64'(n), 64'd3);
        check("ready_flags", 64'({o_ready, o_busy, o_done}), 64'b100);
        for (int i = 0; i < 4; i++) pop_check("basic", exp4[i], 4'hF);
        check("basic_done", 64'({o_ready, o_done}), 64'b01);

        // Replays: the 4-beat pattern three times
        start_load(8'd0, 4'd2, 8'd4, 3'd4, 8'd2, n);
        check("reuse_lat", 64'(n), 64'd3);
        for (int i = 0; i < 12; i++) begin
            pop_check("reuse", exp4[i % 4], 4'hF);
            if (i < 11) check("reuse_notdone", 64'(o_done), 64'd0);
        end
        check("reuse_done", 64'(o_done), 64'd1);

        // Stall on pop deassert
        start_load(8'd0, 4'd2, 8'd4, 3'd4, 8'd0, n);
        pop_check("stall_a", exp4[0], 4'hF);
        i_pop_en = 1'b0;
        tick();
        check("stall_vld", 64'(o_data_valid), 64'd0);
        check("stall_ready", 64'(o_ready), 64'd1);
        pop_check("stall_b", exp4[1], 4'hF);
        pop_check("stall_c", exp4[2], 4'hF);
        pop_check("stall_d", exp4[3], 4'hF);
        check("stall_done", 64'(o_done), 64'd1);

        // Zero route size: first pop finishes with nothing valid
        start_load(8'd0, 4'd2, 8'd0, 3'd4, 8'd0, n);
        pop_check("route0", 32'h0, 4'h0);
        check("route0_done", 64'(o_done), 64'd1);

        // Index beyond the buffer outputs zero but stays valid
        start_load(8'd0, 4'd2, 8'd30, 3'd4, 8'd0, n);
        pop_check("oob", 32'h00000001, 4'hF);

        // Abort in the middle of a load
        i_pop_en = 1'b0;
        i_reg_clear = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        i_start_addr = 8'd0; i_num_words = 4'd2; i_route_size = 8'd4;
        i_ch_active = 3'd4; i_reuse_cnt = 8'd0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        check("abort_busy_pre", 64'(o_busy), 64'd1);
        i_reg_clear = 1'b1;
        i_start = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        i_start = 1'b0;
        check("abort_flags", 64'({o_ready, o_busy, o_done}), 64'b000);
        check("abort_data", 64'(o_data), 64'd0);
        start_load(8'd0, 4'd0, 8'd4, 3'd4, 8'd0, n);
        check("nw0_lat", 64'(n), 64'd1);
        pop_check("abort_buf", 32'h0, 4'hF);

        // Two lanes, route 9: lane1 tail reads unloaded weights 16,17
        i_pop_en = 1'b0;
        i_reg_clear = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        start_load(8'd0, 4'd2, 8'd9, 3'd2, 8'd0, n);
        for (int i = 0; i < 9; i++) begin
            l0 = 8'(i + 1);
            l1 = (i < 7) ? 8'(i + 10) : 8'd0;
            pop_check("ch2", {16'h0, l1, l0}, 4'b0011);
        end
        check("ch2_done", 64'(o_done), 64'd1);

        // Address wrap from 255 to 0
        spad_write(8'd255, 64'hA8A7A6A5A4A3A2A1);
        start_load(8'd255, 4'd2, 8'd8, 3'd2, 8'd0, n);
        pop_check("wrap", 32'h000001A1, 4'b0011);

        // Over-size word count clamps to buffer depth; start ignored while ready
        i_pop_en = 1'b0;
        i_reg_clear = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        start_load(8'd0, 4'd15, 8'd4, 3'd4, 8'd0, n);
        check("clamp_lat", 64'(n), 64'd9);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_ign", 64'({o_ready, o_busy, o_done}), 64'b100);
        pop_check("clamp_pop", exp4[0], 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_weight_router.md
MC_WEIGHT_ROUTER -- requirements
Module: mc_weight_router

Interface
REQ-001 SHALL have parameter SPAD_DATA_WIDTH, default 64, scratchpad word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, weight width; SPAD_N = SPAD_DATA_WIDTH/DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, scratchpad address width.
REQ-004 SHALL have parameter N_CH, default 4, number of parallel output channels.
REQ-005 SHALL have parameter BUF_WORDS, default 8, local buffer depth in scratchpad words; BUF_N = BUF_WORDS*SPAD_N weights.
REQ-006 SHALL have ports: i_clk in 1, clock; i_nrst in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: i_reg_clear in 1, synchronous abort/clear; i_start in 1, begin load.
REQ-008 SHALL have ports: i_spad_write_en in 1; i_write_addr in ADDR_WIDTH; i_data_in in SPAD_DATA_WIDTH, scratchpad write.
REQ-009 SHALL have ports: i_start_addr in ADDR_WIDTH; i_num_words in $clog2(BUF_WORDS+1), words to load.
REQ-010 SHALL have ports: i_route_size in ADDR_WIDTH, weights per channel kernel; i_ch_active in $clog2(N_CH+1), active lanes; i_reuse_cnt in 8, extra replays.
REQ-011 SHALL have ports: i_pop_en in 1, advance stream; o_ready out 1; o_busy out 1; o_done out 1.
REQ-012 SHALL have ports: o_data out N_CH*DATA_WIDTH, lane c at bits [c*DATA_WIDTH +: DATA_WIDTH]; o_data_valid out N_CH.

Function
REQ-013 SHALL implement FSM IDLE, LOAD, DRAIN, READY, STREAM, DONE; o_busy=1 in LOAD/DRAIN/STREAM.
REQ-014 IDLE/DONE + i_start: latch all control inputs, clear counters, go LOAD; i_start elsewhere ignored.
REQ-015 LOAD: one scratchpad read per cycle at i_start_addr+k, k=0..i_num_words-1 (address wraps modulo 2^ADDR_WIDTH), then DRAIN.
REQ-016 Scratchpad read latency 1 cycle; returned word k SHALL be written to buffer word k; same-cycle write/read of one address returns old data.
REQ-017 DRAIN: wait for last returned word, then READY; i_num_words=0 goes LOAD->READY directly; i_num_words>BUF_WORDS SHALL clamp to BUF_WORDS.
REQ-018 o_ready=1 only in READY and STREAM.
REQ-019 READY/STREAM + i_pop_en: lane c (c<i_ch_active) outputs buffer weight c*i_route_size+idx, o_data_valid[c]=1 next cycle; other lanes data 0, valid 0.
REQ-020 Index >= BUF_N SHALL output 0 with valid 1.
REQ-021 i_pop_en=0: o_data_valid all 0, idx held (stall without loss).
REQ-022 idx=i_route_size-1 popped: if replay count < latched i_reuse_cnt, idx=0 and count+1; else DONE.
REQ-023 DONE: o_done=1 until i_start or i_reg_clear; buffer contents retained.
REQ-024 i_route_size=0 or i_ch_active=0: first pop goes DONE with no valid lanes.
REQ-025 i_reg_clear any state: IDLE, counters/outputs zero, in-flight read discarded, buffer zeroed; takes priority over i_start.
REQ-026 Scratchpad writes SHALL be accepted in every state.

Reset
REQ-027 i_nrst low: state IDLE, all counters 0, buffer 0, o_data 0, o_data_valid 0, o_ready 0, o_busy 0, o_done 0.
REQ-028 Scratchpad array contents SHALL NOT be reset.

Structure
REQ-029 FSM state enum and default parameter constants SHALL live in package router_pkg.
REQ-030 Scratchpad SHALL be the existing spad sub-module; no other sub-module.

Verification
REQ-031 SPAD_N=8, words 0..1 = bytes 1..16, i_num_words=2, route 4, ch_active 4, reuse 0, pop held -> cycles: lanes {1,5,9,13},{2,6,10,14},{3,7,11,15},{4,8,12,16}, then o_done.
REQ-032 Same load, reuse 2 -> 12 valid beats, sequence repeated 3 times, then o_done.
REQ-033 Pop toggled 1,0,1 -> no valid on stall cycle, no skipped or duplicated weight.
REQ-034 i_reg_clear during LOAD at k=1 -> IDLE next cycle, o_busy 0, o_data 0, late read data not buffered.
REQ-035 ch_active 2, route 9, i_num_words=2 -> lane1 idx 7..8 (weights 16,17) output 0 valid 1; lanes 2-3 valid 0.
REQ-036 i_start_addr=255, i_num_words=2 -> reads addresses 255 then 0.
